// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the PC/flag unit (PCSour, condition codes, flag bit indices, run state).
package cpu_pkg;
    localparam logic [1:0] PCS_SEQ = 2'b00;
    localparam logic [1:0] PCS_REG = 2'b01;
    localparam logic [1:0] PCS_ALT = 2'b10;
    localparam logic [1:0] PCS_IMM = 2'b11;
    localparam logic [2:0] COND_NE  = 3'b000;
    localparam logic [2:0] COND_EQ  = 3'b001;
    localparam logic [2:0] COND_GT  = 3'b010;
    localparam logic [2:0] COND_LT  = 3'b011;
    localparam logic [2:0] COND_GTE = 3'b100;
    localparam logic [2:0] COND_LTE = 3'b101;
    localparam logic [2:0] COND_OV  = 3'b110;
    localparam logic [2:0] COND_AL  = 3'b111;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;
    typedef enum logic {RUN, HALTED} state_t;
endpackage

// File: rtl/cpu_pc_control_if.sv
// cpu_pc_control_if: decoder/ALU-facing controls and PC/flag outputs; stall exists only with CPU_PC_STALL_EN.
interface cpu_pc_control_if #(parameter int PC_W = 16);
    logic [1:0]      PCSour;
    logic            HLT;
    logic [2:0]      fwr;
    logic            alu_z, alu_v, alu_n;
    logic [2:0]      cond;
    logic [8:0]      imm9;
    logic [PC_W-1:0] rs_data;
`ifdef CPU_PC_STALL_EN
    logic            stall;
`endif
    logic [PC_W-1:0] pc, pc_plus2;
    logic [2:0]      flags;
    logic            branch_taken, halted;
    modport master (
`ifdef CPU_PC_STALL_EN
        output stall,
`endif
        output PCSour, HLT, fwr, alu_z, alu_v, alu_n, cond, imm9, rs_data,
        input  pc, pc_plus2, flags, branch_taken, halted
    );
    modport slave (
`ifdef CPU_PC_STALL_EN
        input  stall,
`endif
        input  PCSour, HLT, fwr, alu_z, alu_v, alu_n, cond, imm9, rs_data,
        output pc, pc_plus2, flags, branch_taken, halted
    );
endinterface

// File: rtl/cpu_branch_cond.sv
// cpu_branch_cond: evaluates a branch condition code against stored {Z,V,N} flags.
module cpu_branch_cond
    import cpu_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       taken
);
    logic z, v, n;
    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    assign n = flags[FLAG_N];
    always_comb begin
        taken = 1'b1;
        case (cond)
            COND_NE:  taken = !z;
            COND_EQ:  taken = z;
            COND_GT:  taken = !z && !n;
            COND_LT:  taken = n;
            COND_GTE: taken = z || (!z && !n);
            COND_LTE: taken = z || n;
            COND_OV:  taken = v;
            default:  taken = 1'b1;
        endcase
    end
endmodule

// File: rtl/cpu_pc_control.sv
// cpu_pc_control: architectural PC, Z/V/N flags and run/halt state of the single-cycle CPU.
// Optional CPU_PC_STALL_EN adds a stall input that freezes the unit while running.
module cpu_pc_control
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input logic              clk,
    input logic              rst_n,
    cpu_pc_control_if.slave  bus
);
    state_t          state, state_nx;
    logic [PC_W-1:0] pc_q, pc_nx, pc_p2, br_off, target;
    logic [2:0]      flags_q, flags_nx, alu_f;
    logic            cond_ok, taken, run;

    cpu_branch_cond u_cond (.cond(bus.cond), .flags(flags_q), .taken(cond_ok));

    // halfword offset: sign-extend imm9 and scale by 2
    assign br_off = {{(PC_W-10){bus.imm9[8]}}, bus.imm9, 1'b0};
    assign pc_p2  = pc_q + PC_W'(2);
    assign alu_f  = {bus.alu_z, bus.alu_v, bus.alu_n};
    assign taken  = state == RUN && (bus.PCSour == PCS_REG || bus.PCSour == PCS_IMM) && cond_ok;
    assign target = !taken ? pc_p2 : bus.PCSour == PCS_IMM ? pc_p2 + br_off : bus.rs_data;
`ifdef CPU_PC_STALL_EN
    assign run = state == RUN && !bus.stall;
`else
    assign run = state == RUN;
`endif

    always_comb begin
        state_nx = state;
        pc_nx    = pc_q;
        flags_nx = flags_q;
        if (run && bus.HLT) begin
            state_nx = HALTED;
        end else if (run) begin
            pc_nx    = target;
            flags_nx = (bus.fwr & alu_f) | (~bus.fwr & flags_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            pc_q    <= RESET_PC;
            flags_q <= 3'b000;
        end else begin
            state   <= state_nx;
            pc_q    <= pc_nx;
            flags_q <= flags_nx;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_plus2     = pc_p2;
    assign bus.flags        = flags_q;
    assign bus.branch_taken = taken;
    assign bus.halted       = state == HALTED;
endmodule

// File: tb/tb_cpu_pc_control.sv
// tb_cpu_pc_control: scoreboard bench; stimulus pushes model expectations, a monitor pops and compares.
module tb_cpu_pc_control;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_pc_control_if #(.PC_W(16)) bus ();
    cpu_pc_control #(.PC_W(16), .RESET_PC(16'h0000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [15:0] pre_pc, pre_p2, pc;
        logic [2:0]  pre_flags, flags;
        logic        pre_halt, taken, halt;
    } rec_t;
    rec_t q[$];

    int checks = 0;
    int errors = 0;

    logic [15:0] m_pc = 16'h0000;
    logic [2:0]  m_flags = 3'b000;
    logic        m_halt = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_cond(input logic [2:0] c);
        logic z, v, n;
        z = m_flags[2]; v = m_flags[1]; n = m_flags[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return z || n;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic drive(input logic [1:0] pcs, input logic hlt, input logic [2:0] fw,
                         input logic [2:0] alu, input logic [2:0] c, input logic [8:0] imm,
                         input logic [15:0] rs, input logic stl);
        bus.PCSour = pcs; bus.HLT = hlt; bus.fwr = fw;
        {bus.alu_z, bus.alu_v, bus.alu_n} = alu;
        bus.cond = c; bus.imm9 = imm; bus.rs_data = rs;
`ifdef CPU_PC_STALL_EN
        bus.stall = stl;
`endif
    endtask

    task automatic cyc(input logic [1:0] pcs, input logic hlt, input logic [2:0] fw,
                       input logic [2:0] alu, input logic [2:0] c, input logic [8:0] imm,
                       input logic [15:0] rs, input logic stl);
        rec_t r;
        logic stalled;
        @(negedge clk);
        rst_n = 1'b1;
        drive(pcs, hlt, fw, alu, c, imm, rs, stl);
`ifdef CPU_PC_STALL_EN
        stalled = stl;
`else
        stalled = 1'b0;
`endif
        r.pre_pc = m_pc; r.pre_p2 = m_pc + 16'd2; r.pre_flags = m_flags; r.pre_halt = m_halt;
        r.taken = !m_halt && (pcs == 2'b01 || pcs == 2'b11) && m_cond(c);
        if (!m_halt && !stalled) begin
            if (hlt) m_halt = 1'b1;
            else begin
                if (r.taken && pcs == 2'b11) m_pc = 16'(int'(m_pc) + 2 + 2 * int'($signed(imm)));
                else if (r.taken) m_pc = rs;
                else m_pc = m_pc + 16'd2;
                for (int i = 0; i < 3; i++) if (fw[i]) m_flags[i] = alu[i];
            end
        end
        r.pc = m_pc; r.flags = m_flags; r.halt = m_halt;
        q.push_back(r);
    endtask

    task automatic reset_cyc();
        rec_t r;
        @(negedge clk);
        rst_n = 1'b0;
        drive(2'b00, 1'b0, 3'b000, 3'b000, 3'b000, 9'h0, 16'h0, 1'b0);
        m_pc = 16'h0000; m_flags = 3'b000; m_halt = 1'b0;
        r.pre_pc = 16'h0000; r.pre_p2 = 16'h0002; r.pre_flags = 3'b000; r.pre_halt = 1'b0;
        r.taken = 1'b0; r.pc = 16'h0000; r.flags = 3'b000; r.halt = 1'b0;
        q.push_back(r);
    endtask

    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                r = q.pop_front();
                chk("pc", bus.pc, r.pre_pc);
                chk("pc_plus2", bus.pc_plus2, r.pre_p2);
                chk("flags", 16'(bus.flags), 16'(r.pre_flags));
                chk("halted", 16'(bus.halted), 16'(r.pre_halt));
                chk("branch_taken", 16'(bus.branch_taken), 16'(r.taken));
                @(posedge clk);
                #1;
                chk("pc_next", bus.pc, r.pc);
                chk("flags_next", 16'(bus.flags), 16'(r.flags));
                chk("halted_next", 16'(bus.halted), 16'(r.halt));
            end
        end
    end

    initial begin
        drive(2'b00, 1'b0, 3'b000, 3'b000, 3'b000, 9'h0, 16'h0, 1'b0);
        reset_cyc();
        repeat (3) cyc(2'b00, 0, 3'b000, 3'b000, 3'd0, 9'h0, 16'h0, 0);
        cyc(2'b01, 0, 3'b000, 3'b000, 3'd7, 9'h0, 16'h000E, 0);
        cyc(2'b00, 0, 3'b000, 3'b000, 3'd0, 9'h0, 16'h0, 0);
        cyc(2'b00, 0, 3'b111, 3'b100, 3'd0, 9'h0, 16'h0, 0);
        cyc(2'b11, 0, 3'b000, 3'b000, 3'd1, 9'h1FE, 16'h0, 0);
        cyc(2'b00, 0, 3'b111, 3'b010, 3'd0, 9'h0, 16'h0, 0);
        cyc(2'b01, 0, 3'b100, 3'b000, 3'd6, 9'h0, 16'h1234, 0);
        cyc(2'b00, 0, 3'b100, 3'b100, 3'd0, 9'h0, 16'h0, 0);
        cyc(2'b11, 0, 3'b000, 3'b000, 3'd0, 9'h010, 16'h0, 0);
        cyc(2'b10, 0, 3'b000, 3'b000, 3'd7, 9'h010, 16'h5555, 0);
        cyc(2'b01, 0, 3'b000, 3'b000, 3'd7, 9'h0, 16'h0040, 0);
        cyc(2'b11, 1, 3'b111, 3'b111, 3'd7, 9'h020, 16'h0, 0);
        repeat (5) cyc(2'b11, 0, 3'b111, 3'b111, 3'd7, 9'h0F0, 16'hAAAA, 0);
        reset_cyc();
        cyc(2'b01, 0, 3'b000, 3'b000, 3'd7, 9'h0, 16'hFFFE, 0);
        cyc(2'b00, 0, 3'b000, 3'b000, 3'd0, 9'h0, 16'h0, 0);
        cyc(2'b00, 0, 3'b111, 3'b011, 3'd0, 9'h0, 16'h0, 0);
`ifdef CPU_PC_STALL_EN
        repeat (2) cyc(2'b11, 1, 3'b111, 3'b100, 3'd7, 9'h040, 16'h0, 1);
`endif
        for (int i = 0; i < 400; i++) begin
            if (m_halt && $urandom_range(0, 3) == 0) reset_cyc();
            else cyc(2'($urandom), $urandom_range(0, 39) == 0, 3'($urandom), 3'($urandom),
                     3'($urandom), 9'($urandom), 16'($urandom), $urandom_range(0, 4) == 0);
        end
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
